abm_ram_read_arbiter: RTL and testbench
=======================================

# abm_ram_read_arbiter

- Round-robin scheduler that shares the single read port of the ABM SDP RAM (registered address in, data out a fixed number of cycles later) between NREQ burst-read requesters.
- Each requester submits a start word address and a beat count, then receives its burst one beat at a time on a valid/ready stream.
- The block sits between the RAM's read side and the requesters, such as the host-facing AXI read slave and internal DMA engines.
- It owns the RAM address bus exclusively.

## Interface
- DW, 512, RAM word / data-beat width in bits
- AW, 10, RAM word-address width
- NREQ, 2, number of requesters (2..4)
- RD_LATENCY, 1, clock edges from a `ram_addr` change to the matching `ram_data`; legal range 1..3
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ram_addr  out  AW  RAM read word address (registered)
- ram_data  in  DW  RAM read data
- req_valid  in  NREQ  per-requester burst request
- req_ready  out  NREQ  per-requester acceptance (combinational from state)
- req_addr  in  NREQ*AW  start word address; requester i uses bits [i*AW +: AW]
- req_len  in  NREQ*8  beats minus 1; requester i uses bits [i*8 +: 8]
- rd_data  out  DW  read beat, shared by all requesters (registered)
- rd_valid  out  NREQ  beat valid, at most one bit set (registered)
- rd_last  out  1  final beat of the current burst (registered)
- rd_ready  in  NREQ  per-requester beat acceptance
- busy  out  1  high in any state other than ARB
- owner  out  2  index of the requester currently or last granted

## Operation
- FSM has three states: ARB, WAIT, DATA.
- ARB:
  - The winner is the first requester with `req_valid` high, searching (last_owner+1) mod NREQ upward with wrap.
  - `req_ready[winner]` is 1; all other `req_ready` bits are 0.
  - On handshake:
    - `owner` <= winner
    - `ram_addr` <= start address
    - `beats_left` <= len
    - `wait_cnt` <= RD_LATENCY
    - state goes to WAIT
  - With no `req_valid`, the FSM stays in ARB.
- WAIT:
  - While `wait_cnt` != 0, decrement it.
  - When `wait_cnt` == 0:
    - `rd_data` <= `ram_data`
    - `rd_valid[owner]` <= 1
    - `rd_last` <= (`beats_left` == 0)
    - state goes to DATA
- DATA:
  - Outputs hold until `rd_ready[owner]`; `rd_ready` bits of non-owners are ignored.
  - On handshake, `rd_valid` <= 0.
  - If `rd_last`: `last_owner` <= `owner`, state goes to ARB.
  - Otherwise:
    - `ram_addr` <= `ram_addr` + 1, modulo 2^AW (wraps from 2^AW-1 to 0)
    - `beats_left` decrements
    - `wait_cnt` <= RD_LATENCY
    - state goes to WAIT
- `req_ready` is 0 in WAIT and DATA. A new request is never accepted in the cycle a burst ends; ARB always costs one cycle.
- Requesters must hold `req_valid`, `req_addr` and `req_len` stable until accepted. Dropping `req_valid` before acceptance withdraws the request.
- `req_len` = 255 gives a 256-beat burst. `beats_left` is 8 bits and never underflows.

## Timing
- Reset values:
  - state ARB, `last_owner` = NREQ-1, so requester 0 has first priority
  - `ram_addr` 0, `rd_data` 0, `rd_valid` 0, `rd_last` 0, `owner` 0, `busy` 0
  - `req_ready` follows the ARB rule immediately after reset deasserts
- Request accepted in cycle T: `ram_addr` valid from T+1, `ram_data` captured at the end of cycle T+1+RD_LATENCY, `rd_valid` high from cycle T+2+RD_LATENCY.
- Beat accepted in cycle D: the next beat is valid from D+2+RD_LATENCY. Back-to-back beat period is RD_LATENCY+2 cycles with `rd_ready` held high.
- Last beat accepted in cycle D: ARB in D+1, so the next grant can handshake in D+1.
- Reset asserted mid-burst: all outputs go to their reset values asynchronously and the burst is abandoned with no further beats. After release the FSM is in ARB.
- `rd_valid` never drops without a handshake, and `rd_data`/`rd_last` are stable while `rd_valid` is high.

## Test plan
- Single burst, RD_LATENCY=1, RAM preloaded with word k = k:
  - Stimulus: req0 addr 5, len 3 accepted at T, `rd_ready[0]` held high.
  - Response: beats 5,6,7,8 appear at T+3, T+6, T+9, T+12, and `rd_last` is high only on 8.
- Contention:
  - Stimulus: req0 and req1 valid from reset, each len 0, with req0 re-requesting continuously.
  - Response: grants are 0, 1, 0, 1…; `owner` toggles; requester 1 never starves.
- Backpressure:
  - Stimulus: `rd_ready[1]` low for 10 cycles on beat 0 of a len 1 burst; `rd_ready[0]` pulsed meanwhile.
  - Response: `rd_valid[1]` and `rd_data` held for 10 cycles; `ram_addr` unchanged; the pulses on `rd_ready[0]` are ignored.
- Address wrap, AW=10:
  - Stimulus: req addr 1022, len 3.
  - Response: `ram_addr` sequence is 1022, 1023, 0, 1, and data matches those words.
- Reset mid-burst:
  - Stimulus: assert `reset` during beat 2 of a len 7 burst.
  - Response: `rd_valid` drops in the same cycle; after release `busy` = 0 and a fresh req1 request is granted with correct data.
- Maximum length:
  - Stimulus: len 255 with RD_LATENCY=3.
  - Response: exactly 256 beats at a 5-cycle period, `rd_last` only on the 256th beat, then return to ARB.

Source files
------------

// File: rtl/abm_ram_read_arbiter.sv
// abm_ram_read_arbiter: round-robin sharing of the ABM SDP RAM read port
// between NREQ burst-read requesters. Each granted burst is fetched one word
// at a time and handed out on a per-requester valid/ready beat stream.
module abm_ram_read_arbiter #(
    parameter int DW         = 512,
    parameter int AW         = 10,
    parameter int NREQ       = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [AW-1:0]       ram_addr,
    input  logic [DW-1:0]       ram_data,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*8-1:0]   req_len,
    output logic [DW-1:0]       rd_data,
    output logic [NREQ-1:0]     rd_valid,
    output logic                rd_last,
    input  logic [NREQ-1:0]     rd_ready,
    output logic                busy,
    output logic [1:0]          owner
);

    typedef enum logic [1:0] {ARB, WAIT, DATA} state_t;

    state_t        state, state_nxt;
    logic [1:0]    last_owner;
    logic [7:0]    beats_left;
    logic [1:0]    wait_cnt;

    logic          win_vld;
    logic [1:0]    win;
    logic [AW-1:0] win_addr;
    logic [7:0]    win_len;
    logic          owner_rdy;

    // Round-robin pick: first valid requester starting just after last_owner.
    always_comb begin
        win_vld  = 1'b0;
        win      = '0;
        win_addr = '0;
        win_len  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win_vld && req_valid[i] && ((int'(last_owner) + k) % NREQ) == i) begin
                    win_vld  = 1'b1;
                    win      = 2'(i);
                    win_addr = req_addr[i*AW +: AW];
                    win_len  = req_len[i*8 +: 8];
                end
            end
        end
    end

    // Only the current owner's rd_ready can complete a beat.
    always_comb begin
        owner_rdy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == 2'(i)) owner_rdy = rd_ready[i];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB;
        else       state <= state_nxt;
    end

    // Next-state and request acceptance; grant only in ARB.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            ARB: begin
                if (win_vld) begin
                    for (int i = 0; i < NREQ; i++) req_ready[i] = (win == 2'(i));
                    state_nxt = WAIT;
                end
            end
            WAIT: if (wait_cnt == 2'd0) state_nxt = DATA;
            DATA: if (owner_rdy) state_nxt = rd_last ? ARB : WAIT;
            default: state_nxt = ARB;
        endcase
    end

    assign busy = (state != ARB);

    // Burst datapath: address stepping, latency wait and beat output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr   <= '0;
            rd_data    <= '0;
            rd_valid   <= '0;
            rd_last    <= 1'b0;
            owner      <= '0;
            last_owner <= 2'(NREQ - 1);
            beats_left <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (win_vld) begin
                        owner      <= win;
                        ram_addr   <= win_addr;
                        beats_left <= win_len;
                        wait_cnt   <= 2'(RD_LATENCY);
                    end
                end
                WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        rd_data <= ram_data;
                        rd_last <= (beats_left == 8'd0);
                        for (int i = 0; i < NREQ; i++) rd_valid[i] <= (owner == 2'(i));
                    end
                end
                DATA: begin
                    if (owner_rdy) begin
                        rd_valid <= '0;
                        if (rd_last) begin
                            last_owner <= owner;
                        end else begin
                            ram_addr   <= ram_addr + 1'b1;
                            beats_left <= beats_left - 8'd1;
                            wait_cnt   <= 2'(RD_LATENCY);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_abm_ram_read_arbiter.sv
// Bench for abm_ram_read_arbiter: two instances (read latency 1 and 3), each
// driven through directed scenarios and random traffic, compared every cycle
// against a cycle-level model built from grant order and beat timing rules.
module tb_abm_ram_read_arbiter;

    localparam int DW = 512, AW = 10, NREQ = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input int lat, input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL L%0d %s: got %0h expected %0h", lat, tag, act, exp);
        end
    endtask

    // RAM contents: the low 10 bits of word k equal k.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {16{22'h2AB5C3, a}};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int L = (g == 0) ? 1 : 3;

        logic               rst;
        logic [AW-1:0]      ram_addr;
        logic [DW-1:0]      ram_data;
        logic [NREQ-1:0]    req_valid, req_ready;
        logic [NREQ*AW-1:0] req_addr;
        logic [NREQ*8-1:0]  req_len;
        logic [DW-1:0]      rd_data;
        logic [NREQ-1:0]    rd_valid, rd_ready;
        logic               rd_last, busy;
        logic [1:0]         owner;
        logic [DW-1:0]      rpipe [3];
        bit                 done;

        abm_ram_read_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ), .RD_LATENCY(L)) u_dut (
            .clk(clk), .reset(rst), .ram_addr(ram_addr), .ram_data(ram_data),
            .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
            .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
            .busy(busy), .owner(owner)
        );

        // RAM read port with L edges from address to data.
        always @(posedge clk) begin
            rpipe[0] <= word(ram_addr);
            rpipe[1] <= rpipe[0];
            rpipe[2] <= rpipe[1];
        end
        assign ram_data = rpipe[L-1];

        initial begin : run
            int c, phase, pc, lo, own, cur, idx, len, base, valid_at, exp_addr;
            int w, prev_w, grants, hold, nbeats, last_hs, t_acc, stage;
            bit active, armed, in_arb, bv;
            logic [NREQ-1:0] acc, exp_rdy, exp_vld;
            int wl [4];
            wl = '{1022, 1023, 0, 1};
            rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; rd_ready = '0; done = 1'b0;
            c = 0; phase = 0; pc = 0; lo = NREQ - 1; own = 0; cur = 0; idx = 0; len = 0; base = 0;
            valid_at = 0; exp_addr = 0; prev_w = 0; grants = 0; hold = 0; nbeats = 0; last_hs = 0;
            t_acc = 0; stage = 0; active = 1'b0; armed = 1'b0; acc = '0;
            while (phase < 8) begin
                @(posedge clk); #1;
                c++; pc++;
                if (phase != 2) req_valid = req_valid & ~acc;
                case (phase)
                    0: rst = (pc < 3);
                    1: if (pc == 1) begin
                        rd_ready = '1; req_addr[0 +: AW] = 10'd5; req_len[0 +: 8] = 8'd3;
                        req_valid[0] = 1'b1; armed = 1'b1;
                    end
                    2: if (pc == 1) begin
                        req_addr = {10'($urandom), 10'($urandom)}; req_len = '0; req_valid = '1;
                    end else if (grants >= 8) begin
                        req_valid = '0; armed = 1'b1;
                    end
                    3: begin
                        if (pc == 1) begin
                            req_addr[AW +: AW] = 10'($urandom); req_len[8 +: 8] = 8'd1;
                            req_valid[1] = 1'b1; armed = 1'b1;
                        end
                        rd_ready[0] = pc[0];
                        rd_ready[1] = (hold >= 10);
                    end
                    4: if (pc == 1) begin
                        rd_ready = '1; req_addr[0 +: AW] = 10'd1022; req_len[0 +: 8] = 8'd3;
                        req_valid[0] = 1'b1; armed = 1'b1;
                    end
                    5: begin
                        if (pc == 1) begin
                            rd_ready = '1; req_addr[0 +: AW] = 10'($urandom); req_len[0 +: 8] = 8'd7;
                            req_valid[0] = 1'b1; stage = 0;
                        end else if (stage == 0 && active && idx == 2 && c >= valid_at) begin
                            rst = 1'b1; req_valid = '0; stage = 1;
                        end else if (stage == 1) begin
                            rst = 1'b0; req_addr[AW +: AW] = 10'($urandom);
                            req_len[8 +: 8] = 8'($urandom_range(7, 0));
                            req_valid[1] = 1'b1; stage = 2; armed = 1'b1;
                        end
                    end
                    6: if (pc == 1) begin
                        rd_ready = '1; req_addr[0 +: AW] = 10'($urandom); req_len[0 +: 8] = 8'd255;
                        req_valid[0] = 1'b1; armed = 1'b1;
                    end
                    7: if (pc <= 1500) begin
                        for (int i = 0; i < NREQ; i++) begin
                            if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
                                req_addr[i*AW +: AW] = 10'($urandom);
                                req_len[i*8 +: 8] = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(31, 0))
                                                                              : 8'($urandom_range(3, 0));
                                req_valid[i] = 1'b1;
                            end
                        end
                        rd_ready = 2'($urandom);
                    end else begin
                        req_valid = '0; rd_ready = '1; armed = 1'b1;
                    end
                    default: ;
                endcase

                @(negedge clk);
                if (rst) begin
                    active = 1'b0; lo = NREQ - 1; own = 0; exp_addr = 0;
                end
                in_arb = !active;
                w = -1;
                if (in_arb)
                    for (int k = 1; k <= NREQ; k++)
                        if (w < 0 && req_valid[(lo + k) % NREQ]) w = (lo + k) % NREQ;
                exp_rdy = '0;
                if (w >= 0) exp_rdy[w] = 1'b1;
                bv = active && c >= valid_at;
                exp_vld = '0;
                if (bv) exp_vld[cur] = 1'b1;

                chk(L, "req_ready", req_ready, exp_rdy);
                chk(L, "busy", busy, !in_arb);
                chk(L, "owner", owner, own);
                chk(L, "ram_addr", ram_addr, exp_addr);
                chk(L, "rd_valid", rd_valid, exp_vld);
                if (bv) begin
                    chk(L, "rd_data", rd_data, word(10'((base + idx) % 1024)));
                    chk(L, "rd_last", rd_last, idx == len);
                end
                if (rst) begin
                    chk(L, "reset_rd_data", rd_data, 0);
                    chk(L, "reset_rd_last", rd_last, 0);
                end
                if (phase == 3 && bv && idx == 0) hold++;

                acc = '0;
                if (w >= 0) begin
                    acc[w] = 1'b1; active = 1'b1; cur = w; own = w;
                    base = int'(req_addr[w*AW +: AW]); len = int'(req_len[w*8 +: 8]);
                    idx = 0; valid_at = c + 2 + L; exp_addr = base; t_acc = c;
                    if (phase == 2) begin
                        if (grants > 0) chk(L, "rr_alternate", w, prev_w ^ 1);
                        prev_w = w; grants++;
                    end
                end else if (bv && rd_ready[cur]) begin
                    if (phase == 1) begin
                        chk(L, "single_beat_cycle", c, t_acc + (idx + 1) * (L + 2));
                        chk(L, "single_beat_word", rd_data[9:0], 5 + idx);
                    end
                    if (phase == 4) chk(L, "wrap_addr", ram_addr, wl[idx]);
                    if (phase == 6) begin
                        if (idx > 0) chk(L, "max_len_period", c - last_hs, L + 2);
                        last_hs = c;
                    end
                    nbeats++;
                    if (idx == len) begin
                        active = 1'b0; lo = cur;
                    end else begin
                        idx++; exp_addr = (base + idx) % 1024; valid_at = c + 2 + L;
                    end
                end

                if (armed && req_valid == '0 && !active) begin
                    if (phase == 1) chk(L, "single_beats", nbeats, 4);
                    if (phase == 3) chk(L, "bp_hold_cycles", hold, 11);
                    if (phase == 6) chk(L, "max_len_beats", nbeats, 256);
                    phase++; pc = 0; armed = 1'b0; nbeats = 0; hold = 0; grants = 0;
                end else if (phase == 0 && pc == 4) begin
                    phase = 1; pc = 0;
                end else if (pc > 4000) begin
                    chk(L, "phase_timeout", phase, 99);
                    phase++; pc = 0; armed = 1'b0; req_valid = '0; rst = 1'b0;
                end
            end
            done = 1'b1;
        end
    end

    initial begin : finish_blk
        int t;
        t = 0;
        while (!(gi[0].done && gi[1].done) && t < 50000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 50000) chk(0, "global_timeout", t, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
